// File: rtl/alu_exec_unit_pkg.sv
// Shared widths, op encodings and the combinational base ALU for the execution stage.
package alu_exec_unit_pkg;

  localparam int XLEN      = 32;
  localparam int OP_W      = 5;
  localparam int ROB_IDX_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_OP_ADD    = 5'd0,
    ALU_OP_SUB    = 5'd1,
    ALU_OP_AND    = 5'd2,
    ALU_OP_OR     = 5'd3,
    ALU_OP_XOR    = 5'd4,
    ALU_OP_SLL    = 5'd5,
    ALU_OP_SRL    = 5'd6,
    ALU_OP_SRA    = 5'd7,
    ALU_OP_SLT    = 5'd8,
    ALU_OP_SLTU   = 5'd9,
    ALU_OP_EQ     = 5'd10,
    ALU_OP_NE     = 5'd11,
    ALU_OP_LT     = 5'd12,
    ALU_OP_GE     = 5'd13,
    ALU_OP_LTU    = 5'd14,
    ALU_OP_GEU    = 5'd15,
    ALU_OP_MUL    = 5'd16,
    ALU_OP_MULH   = 5'd17,
    ALU_OP_MULHSU = 5'd18,
    ALU_OP_MULHU  = 5'd19
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mul_state_e;

  function automatic logic is_mul_op(logic [OP_W-1:0] op);
    return op inside {ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU};
  endfunction

  // Multiply encodings fall through to zero; they only reach here when the multiplier is absent.
  function automatic logic [XLEN-1:0] alu_base(logic [OP_W-1:0] op,
                                               logic [XLEN-1:0] a,
                                               logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (alu_op_e'(op))
      ALU_OP_ADD:  r = a + b;
      ALU_OP_SUB:  r = a - b;
      ALU_OP_AND:  r = a & b;
      ALU_OP_OR:   r = a | b;
      ALU_OP_XOR:  r = a ^ b;
      ALU_OP_SLL:  r = a << b[4:0];
      ALU_OP_SRL:  r = a >> b[4:0];
      ALU_OP_SRA:  r = $signed(a) >>> b[4:0];
      ALU_OP_SLT,
      ALU_OP_LT:   r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_OP_SLTU,
      ALU_OP_LTU:  r = {{(XLEN-1){1'b0}}, a < b};
      ALU_OP_EQ:   r = {{(XLEN-1){1'b0}}, a == b};
      ALU_OP_NE:   r = {{(XLEN-1){1'b0}}, a != b};
      ALU_OP_GE:   r = {{(XLEN-1){1'b0}}, $signed(a) >= $signed(b)};
      ALU_OP_GEU:  r = {{(XLEN-1){1'b0}}, a >= b};
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue and write-back bus between the reservation station and the ALU execution stage.
interface alu_exec_unit_if;
  import alu_exec_unit_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [OP_W-1:0]      in_op;
  logic [XLEN-1:0]      in_r1;
  logic [XLEN-1:0]      in_r2;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic                 wb_valid;
  logic [ROB_IDX_W-1:0] wb_idx;
  logic [XLEN-1:0]      wb_value;

  modport master (
    output in_valid, in_op, in_r1, in_r2, in_rob_idx,
    input  in_ready, wb_valid, wb_idx, wb_value
  );

  modport slave (
    input  in_valid, in_op, in_r1, in_r2, in_rob_idx,
    output in_ready, wb_valid, wb_idx, wb_value
  );

endinterface

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative 32x32 shift-add multiplier on unsigned magnitudes with a final sign fix-up.
module alu_mul_iter
  import alu_exec_unit_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en,
  input  logic              flush,
  input  logic              start,
  input  logic              a_signed,
  input  logic              b_signed,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  logic [2*XLEN-1:0] mcand_q, acc_q, acc_sum;
  logic [XLEN-1:0]   mplier_q, a_mag, b_mag;
  logic [4:0]        cnt_q;
  logic              neg_q, a_neg, b_neg;

  assign a_neg = a_signed && a[XLEN-1];
  assign b_neg = b_signed && b[XLEN-1];
  assign a_mag = a_neg ? (~a + XLEN'(1)) : a;
  assign b_mag = b_neg ? (~b + XLEN'(1)) : b;

  // The product is taken from the sum of the final iteration so it lands on the done edge.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product = neg_q ? (~acc_sum + (2*XLEN)'(1)) : acc_sum;
  assign done    = busy && (cnt_q == 5'd31);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else if (en) begin
      if (flush) begin
        busy  <= 1'b0;
        cnt_q <= '0;
      end else if (start) begin
        busy     <= 1'b1;
        cnt_q    <= '0;
        acc_q    <= '0;
        mcand_q  <= {{XLEN{1'b0}}, a_mag};
        mplier_q <= b_mag;
        neg_q    <= a_neg ^ b_neg;
      end else if (busy) begin
        acc_q    <= acc_sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 5'd1;
        if (done) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution stage: single-cycle base ALU feeding a registered write-back broadcast.
// Define ALU_MUL_EN to add the iterative M-extension multiplier and its IDLE/BUSY wrapper.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           rob_clear,
  alu_exec_unit_if.slave bus
);

  logic                 accept, base_fire, mul_fire;
  logic [XLEN-1:0]      alu_result, mul_result;
  logic [ROB_IDX_W-1:0] mul_tag;

  assign accept     = bus.in_valid && bus.in_ready && rdy_in && !rob_clear;
  assign alu_result = alu_base(bus.in_op, bus.in_r1, bus.in_r2);

`ifdef ALU_MUL_EN
  // state   | meaning
  // ST_IDLE | accepting ops; base ops retire in one cycle
  // ST_BUSY | multiply iterating; issue blocked until done
  mul_state_e           state_q, state_d;
  logic                 start, mul_busy, mul_done, a_signed, b_signed, mul_hi_q;
  logic [2*XLEN-1:0]    product;
  logic [ROB_IDX_W-1:0] mul_tag_q;

  assign start    = accept && is_mul_op(bus.in_op);
  assign a_signed = bus.in_op inside {ALU_OP_MULH, ALU_OP_MULHSU};
  assign b_signed = (bus.in_op == ALU_OP_MULH);

  alu_mul_iter u_mul (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en       (rdy_in),
    .flush    (rob_clear),
    .start    (start),
    .a_signed (a_signed),
    .b_signed (b_signed),
    .a        (bus.in_r1),
    .b        (bus.in_r2),
    .busy     (mul_busy),
    .done     (mul_done),
    .product  (product)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      mul_tag_q <= '0;
      mul_hi_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      if (start) begin
        mul_tag_q <= bus.in_rob_idx;
        mul_hi_q  <= (bus.in_op != ALU_OP_MUL);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      // A BUSY state without an iterating multiplier cannot finish, so fall back to IDLE.
      ST_BUSY: if (mul_done || !mul_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (rob_clear) state_d = ST_IDLE;
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign base_fire    = accept && !is_mul_op(bus.in_op);
  assign mul_fire     = mul_done;
  assign mul_result   = mul_hi_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
  assign mul_tag      = mul_tag_q;
`else
  assign bus.in_ready = 1'b1;
  assign base_fire    = accept;
  assign mul_fire     = 1'b0;
  assign mul_result   = '0;
  assign mul_tag      = '0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.wb_valid <= 1'b0;
      bus.wb_idx   <= '0;
      bus.wb_value <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        bus.wb_valid <= 1'b0;
      end else if (base_fire) begin
        bus.wb_valid <= 1'b1;
        bus.wb_idx   <= bus.in_rob_idx;
        bus.wb_value <= alu_result;
      end else if (mul_fire) begin
        bus.wb_valid <= 1'b1;
        bus.wb_idx   <= mul_tag;
        bus.wb_value <= mul_result;
      end else begin
        bus.wb_valid <= 1'b0;
      end
    end
  end

endmodule
